rdyacpt_fifo: RTL and testbench
===============================

# rdyacpt_fifo

Elastic buffer stage sitting directly downstream of a rdy/acpt producer. It accepts words on an upstream rdy/acpt port, stores up to DEPTH of them in order, and re-presents them on a downstream rdy/acpt port. This decouples producer and consumer stalls. Both ports obey the same handshake rules as the rest of the design, so the block can be inserted on any rdy/acpt link without changing either neighbour.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 4, number of storage entries; power of 2, minimum 2
- clk  input  1  sole clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- rdy_di  input  1  upstream word valid
- data_di  input  WIDTH  upstream word
- acpt_di  output  1  block can take a word this cycle
- rdy_do  output  1  downstream word valid
- data_do  output  WIDTH  word at head of buffer
- acpt_do  input  1  downstream consumer takes the word
- level  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH

## Operation
- Transfer rule, both ports: a word moves on a posedge where rdy and acpt are both 1.
- Sender obligation: once rdy is raised, it stays high and its data stays stable until that transfer edge.
- push = rdy_di & acpt_di.
- pop = rdy_do & acpt_do.
- Storage: DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits.
- On push: mem[wr_ptr] <= data_di; wr_ptr increments.
- On pop: rd_ptr increments.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on push and pop together, or on neither
- acpt_di = (count != DEPTH), decoded from registered count. It never depends combinationally on acpt_do, so no full-bypass path exists.
- rdy_do = (count != 0), from registered count.
- data_do = mem[rd_ptr]: first-word fall-through, no read register.
- level = count.
- Downstream protocol is met by construction:
  - rdy_do cannot drop without a pop.
  - mem[rd_ptr] is never written while count != 0 and rd_ptr is unchanged, because wr_ptr equals rd_ptr only when empty or full, and a push cannot occur when full.
- States (implicit in count):
  - EMPTY (0): acpt_di=1, rdy_do=0
  - PARTIAL (1..DEPTH-1): both 1
  - FULL (DEPTH): acpt_di=0, rdy_do=1
- Boundaries:
  - FULL with pop: pop occurs and no push that cycle; acpt_di returns to 1 the next cycle.
  - EMPTY with rdy_di: push occurs and no pop; rdy_do rises the next cycle.
  - Pointer wrap DEPTH-1 -> 0 must be seamless; ordering is preserved across wrap.
  - Any rdy_do/acpt_do or rdy_di/acpt_di value without the matching partner bit causes no state change.
- Reset, asserted at any time including mid-transfer:
  - wr_ptr, rd_ptr and count go to 0; all mem entries go to 0.
  - Stored words are discarded.
  - Outputs while reset=1: acpt_di=0, rdy_do=0, data_do=0, level=0.

## Timing
- Latency: a word pushed at edge N appears on data_do with rdy_do=1 in the cycle after edge N, provided the buffer was empty. Otherwise it appears after all older words pop.
- Throughput: 1 word/cycle sustained when both sides stream; no bubble at the EMPTY, FULL or wrap transitions.
- acpt_di is first high in the cycle after reset deasserts (registered count=0).
- acpt_di and rdy_do change only after posedge clk or reset assertion; they are glitch-free relative to acpt_do and rdy_di.
- level reflects the state after the most recent edge.

## Test plan
- Reset, then single word: push 0xA5 at edge 1 -> rdy_do=1, data_do=0xA5, level=1 after edge 1; acpt_do=1 at edge 2 -> rdy_do=0, level=0.
- Fill (DEPTH=4), acpt_do=0: push 0x01..0x04 -> acpt_di=0 and level=4 after the 4th edge; rdy_di held high with 0x05 is not taken for 3 stall cycles. Pop once -> acpt_di=1 next cycle, 0x05 taken, order 0x01..0x05 out.
- Streaming: rdy_di=acpt_do=1 for 20 cycles with incrementing data 0x00..0x13 -> output identical sequence, level constant at 1, no bubbles, pointers wrap 5 times.
- Random stalls: 200 words, 50% random deassertion of rdy_di and acpt_do -> output matches scoreboard. The handshake-hold and data-stable checks on both ports never fire.
- Simultaneous push/pop at FULL and EMPTY boundaries: at level=4 with acpt_do=1 and rdy_di=1 -> only pop, level=3. At level=0 with both -> only push, level=1.
- Reset mid-operation: level=3, assert reset between edges -> rdy_do=0, acpt_di=0, data_do=0, level=0 immediately. After release, push 0x3C -> data_do=0x3C and no stale word appears.

Source files
------------

// File: rtl/rdyacpt_fifo.sv
// rdyacpt_fifo: elastic rdy/acpt buffer stage with first-word fall-through.
// Words taken on the upstream port are stored in order and re-presented on
// the downstream port. Flow-control outputs decode only from registered count.
module rdyacpt_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rdy_di,
  input  logic [WIDTH-1:0]         data_di,
  output logic                     acpt_di,
  output logic                     rdy_do,
  output logic [WIDTH-1:0]         data_do,
  input  logic                     acpt_do,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Handshakes: a word moves on either port only when both sides agree.
  always_comb begin
    push = rdy_di & acpt_di;
    pop  = rdy_do & acpt_do;
  end

  // Storage array; reset wipes every entry so no stale word can resurface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= data_di;
    end
  end

  // Write and read pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Flow-control outputs from registered count; acpt_di held low during reset
  // because count=0 would otherwise advertise space while reset is asserted.
  always_comb begin
    acpt_di = ~reset & (count != FULL_CNT);
    rdy_do  = (count != '0);
    data_do = mem[rd_ptr];
    level   = count;
  end

endmodule

// File: tb/tb_rdyacpt_fifo.sv
// Testbench for rdyacpt_fifo: queue-based reference model, scoreboard monitor
// on the downstream port, directed boundary phases and a random-stall phase.
module tb_rdyacpt_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rdy_di = 1'b0;
  logic [WIDTH-1:0] data_di = '0;
  logic             acpt_di;
  logic             rdy_do;
  logic [WIDTH-1:0] data_do;
  logic             acpt_do = 1'b0;
  logic [2:0]       level;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;

  // Reference model: the buffer contents in order, head at index 0.
  logic [WIDTH-1:0] sb [$];
  logic             last_push = 1'b0;
  logic             last_pop  = 1'b0;
  logic             prev_rdy  = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  rdyacpt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .rdy_di  (rdy_di),
    .data_di (data_di),
    .acpt_di (acpt_di),
    .rdy_do  (rdy_do),
    .data_do (data_do),
    .acpt_do (acpt_do),
    .level   (level)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reset discards everything the model holds.
  always @(posedge reset) begin
    sb.delete();
    last_push = 1'b0;
    last_pop  = 1'b0;
    prev_rdy  = 1'b0;
  end

  // Model step and scoreboard monitor: decide transfers from the model's own
  // occupancy, compare every popped word against the expected head.
  always @(posedge clk) begin
    logic p, q;
    logic [WIDTH-1:0] e;
    if (!reset) begin
      p = rdy_di && (sb.size() != DEPTH);
      q = acpt_do && (sb.size() != 0);
      if (q) begin
        e = sb.pop_front();
        chk("pop_data", int'(data_do), int'(e));
        n_pop++;
      end
      if (p) begin
        sb.push_back(data_di);
        n_push++;
      end
      last_push = p;
      last_pop  = q;
    end
  end

  // Output checker, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_acpt_di", int'(acpt_di), 0);
      chk("rst_rdy_do",  int'(rdy_do),  0);
      chk("rst_data_do", int'(data_do), 0);
      chk("rst_level",   int'(level),   0);
      prev_rdy = 1'b0;
    end else begin
      chk("level",   int'(level),   sb.size());
      chk("acpt_di", int'(acpt_di), int'(sb.size() != DEPTH));
      chk("rdy_do",  int'(rdy_do),  int'(sb.size() != 0));
      if (sb.size() != 0) chk("data_do", int'(data_do), int'(sb[0]));
      if (prev_rdy && !last_pop) begin
        chk("hold_rdy_do",  int'(rdy_do),  1);
        chk("hold_data_do", int'(data_do), int'(prev_data));
      end
      prev_rdy  = rdy_do;
      prev_data = data_do;
    end
  end

  // Apply inputs just after a negedge and hold them for n cycles.
  task automatic drive(input logic r, input logic [WIDTH-1:0] d, input logic a, input int n);
    rdy_di  = r;
    data_di = d;
    acpt_do = a;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int issued;
    int cyc;
    int base;

    // Reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("acpt_after_reset", int'(acpt_di), 1);

    // Single word
    drive(1'b1, 8'hA5, 1'b0, 1);
    chk("single_rdy",   int'(rdy_do),  1);
    chk("single_data",  int'(data_do), 8'hA5);
    chk("single_level", int'(level),   1);
    drive(1'b0, 8'h00, 1'b1, 1);
    chk("single_drain", int'(level), 0);
    drive(1'b0, 8'h00, 1'b0, 1);

    // Fill with consumer stalled, then release one slot
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 1);
    chk("full_acpt",  int'(acpt_di), 0);
    chk("full_level", int'(level),   4);
    drive(1'b1, 8'h05, 1'b0, 3);
    chk("stall_level", int'(level), 4);
    drive(1'b1, 8'h05, 1'b1, 1);
    chk("full_pop_only", int'(level),   3);
    chk("acpt_returns",  int'(acpt_di), 1);
    drive(1'b1, 8'h05, 1'b1, 1);
    drive(1'b0, 8'h00, 1'b1, 4);
    chk("fill_pops", n_pop, 6);
    drive(1'b0, 8'h00, 1'b0, 1);

    // Streaming: empty-boundary push-only, then one in one out
    base = n_pop;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1);
      chk("stream_level", int'(level), 1);
    end
    chk("stream_pops", n_pop - base, 19);
    drive(1'b0, 8'h00, 1'b1, 2);
    drive(1'b0, 8'h00, 1'b0, 1);

    // Random stalls on both sides, sender obeys hold rule
    base   = n_push;
    issued = 0;
    cyc    = 0;
    while (cyc < 3000) begin
      if (rdy_di && !last_push) begin
        // hold word until taken
      end else if (issued >= 200) begin
        break;
      end else if ($urandom_range(1) == 1) begin
        rdy_di  = 1'b1;
        data_di = 8'($urandom);
        issued++;
      end else begin
        rdy_di  = 1'b0;
        data_di = 8'($urandom);
      end
      acpt_do = 1'($urandom_range(1));
      @(negedge clk);
      cyc++;
    end
    rdy_di = 1'b0;
    chk("random_pushes", n_push - base, 200);
    acpt_do = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("random_drain", int'(level), 0);
    drive(1'b0, 8'h00, 1'b0, 1);

    // Reset mid-operation
    drive(1'b1, 8'h11, 1'b0, 1);
    drive(1'b1, 8'h22, 1'b0, 1);
    drive(1'b1, 8'h33, 1'b0, 1);
    drive(1'b0, 8'h00, 1'b0, 0);
    chk("pre_reset_level", int'(level), 3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rdy",   int'(rdy_do),  0);
    chk("mid_rst_acpt",  int'(acpt_di), 0);
    chk("mid_rst_data",  int'(data_do), 0);
    chk("mid_rst_level", int'(level),   0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    drive(1'b1, 8'h3C, 1'b0, 1);
    chk("post_rst_data",  int'(data_do), 8'h3C);
    chk("post_rst_level", int'(level),   1);
    drive(1'b0, 8'h00, 1'b1, 1);
    chk("post_rst_empty", int'(rdy_do), 0);
    drive(1'b0, 8'h00, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
